// File: rtl/arb_pkg.sv
// arb_pkg: shared state encodings for the round-robin stream arbiter.
package arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;
endpackage

// File: rtl/mux2x1_struct.sv
// mux2x1_struct: one-bit 2:1 data mux slice.
module mux2x1_struct (
    input  logic S,
    input  logic I0,
    input  logic I1,
    output logic Y
);
    assign Y = S ? I1 : I0;
endmodule

// File: rtl/arb2x1_rr_stream.sv
// arb2x1_rr_stream: two-input round-robin stream arbiter with packet lock
// and a single registered output stage.
module arb2x1_rr_stream
    import arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready
);
    state_t           state, state_nxt;
    logic             prio, grant, can_load, acc, grant_last;
    logic [WIDTH-1:0] mux_data;

    assign can_load   = ~out_valid | out_ready;
    assign grant_last = grant ? in1_last : in0_last;
    assign acc        = grant ? (in1_valid & in1_ready) : (in0_valid & in0_ready);

    // A lock pins the grant; otherwise a lone requester wins and ties go to prio.
    always_comb
        grant = (state == ST_LOCK0) ? 1'b0 :
                (state == ST_LOCK1) ? 1'b1 :
                (in0_valid & in1_valid) ? prio : in1_valid;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;

    // The unused encoding falls back to IDLE.
    always_comb
        state_nxt = acc ? (grant_last ? ST_IDLE : (grant ? ST_LOCK1 : ST_LOCK0)) :
                    (state == ST_LOCK0 || state == ST_LOCK1) ? state : ST_IDLE;

    always_comb begin
        in0_ready = ~rst & can_load & ~grant;
        in1_ready = ~rst & can_load & grant;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux2x1_struct u_mux (
            .S (grant),
            .I0(in0_data[i]),
            .I1(in1_data[i]),
            .Y (mux_data[i])
        );
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)                   prio <= 1'b0;
        else if (acc & grant_last) prio <= ~grant;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_last  <= grant_last;
            out_src   <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
endmodule

// File: tb/tb_arb2x1_rr_stream.sv
// tb_arb2x1_rr_stream: vector table, hand-written corner sequences and a
// randomized run against a behavioural model.
module tb_arb2x1_rr_stream;
    logic       clk, rst;
    logic       in0_valid, in0_last, in0_ready;
    logic       in1_valid, in1_last, in1_ready;
    logic [7:0] in0_data, in1_data, out_data;
    logic       out_valid, out_last, out_src, out_ready;
    int         tests = 0, fails = 0;

    arb2x1_rr_stream #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v0; logic [7:0] d0; logic l0;
        logic       v1; logic [7:0] d1; logic l1;
        logic       ordy;
        logic       r0, r1;
        logic       ov; logic [7:0] od; logic ol; logic os;
    } vec_t;
    vec_t vec[11];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                         input logic v1, input logic [7:0] d1, input logic l1, input logic ordy);
        in0_valid = v0; in0_data = d0; in0_last = l0;
        in1_valid = v1; in1_data = d1; in1_last = l1;
        out_ready = ordy;
    endtask

    task automatic chk_rdy(input string nm, input logic r0, input logic r1);
        #1;
        chk({nm, ".in0_ready"}, in0_ready, r0);
        chk({nm, ".in1_ready"}, in1_ready, r1);
    endtask

    task automatic chk_out(input string nm, input logic ov, input logic [7:0] od,
                           input logic ol, input logic os);
        chk({nm, ".out_valid"}, out_valid, ov);
        chk({nm, ".out_data"}, out_data, od);
        chk({nm, ".out_last"}, out_last, ol);
        chk({nm, ".out_src"}, out_src, os);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    // Behavioural reference: lock owner (-1 = none), tie priority, output stage.
    int         m_lock;
    bit         m_prio, m_ov, m_ol, m_os;
    logic [7:0] m_od;
    logic       sv[2], sl[2];
    logic [7:0] sd[2];

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        tick;
        tick;
        //          rst v0 d0    l0 v1 d1    l1 rdy r0 r1 ov od    ol os
        vec[0]  = '{1, 1, 8'hA5, 1, 1, 8'h3C, 1, 1, 0, 0, 0, 8'h00, 0, 0};
        vec[1]  = '{0, 1, 8'hA5, 1, 1, 8'h3C, 1, 1, 1, 0, 1, 8'hA5, 1, 0};
        vec[2]  = '{0, 1, 8'hA5, 1, 1, 8'h3C, 1, 1, 0, 1, 1, 8'h3C, 1, 1};
        vec[3]  = '{0, 1, 8'hA5, 1, 1, 8'h3C, 1, 1, 1, 0, 1, 8'hA5, 1, 0};
        vec[4]  = '{0, 1, 8'hA5, 1, 1, 8'h3C, 1, 1, 0, 1, 1, 8'h3C, 1, 1};
        vec[5]  = '{1, 1, 8'h11, 0, 1, 8'h44, 1, 1, 0, 0, 0, 8'h00, 0, 0};
        vec[6]  = '{0, 1, 8'h11, 0, 1, 8'h44, 1, 1, 1, 0, 1, 8'h11, 0, 0};
        vec[7]  = '{0, 1, 8'h22, 0, 1, 8'h44, 1, 1, 1, 0, 1, 8'h22, 0, 0};
        vec[8]  = '{0, 1, 8'h33, 1, 1, 8'h44, 1, 1, 1, 0, 1, 8'h33, 1, 0};
        vec[9]  = '{0, 0, 8'h00, 0, 1, 8'h44, 1, 1, 0, 1, 1, 8'h44, 1, 1};
        vec[10] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 0, 8'h44, 1, 1};
        for (int i = 0; i < 11; i++) begin
            rst = vec[i].rst;
            drive(vec[i].v0, vec[i].d0, vec[i].l0, vec[i].v1, vec[i].d1, vec[i].l1, vec[i].ordy);
            chk_rdy($sformatf("vec%0d", i), vec[i].r0, vec[i].r1);
            tick;
            chk_out($sformatf("vec%0d", i), vec[i].ov, vec[i].od, vec[i].ol, vec[i].os);
        end
        rst = 1'b0;

        // Gap mid-packet: in1 stays locked out until in0 finishes.
        do_reset;
        drive(1, 8'h11, 0, 1, 8'h55, 1, 1);
        tick;
        chk_out("gap.b1", 1, 8'h11, 0, 0);
        drive(0, 8'h00, 0, 1, 8'h55, 1, 1);
        for (int i = 0; i < 3; i++) begin
            chk_rdy($sformatf("gap%0d", i), 1, 0);
            tick;
            chk("gap.out_valid", out_valid, 0);
        end
        drive(1, 8'h22, 1, 1, 8'h55, 1, 1);
        tick;
        chk_out("gap.b2", 1, 8'h22, 1, 0);
        drive(0, 8'h00, 0, 1, 8'h55, 1, 1);
        tick;
        chk_out("gap.in1", 1, 8'h55, 1, 1);

        // Stall for 4 clocks, then drain and accept together.
        do_reset;
        drive(1, 8'h5A, 1, 0, 8'h00, 0, 1);
        tick;
        drive(0, 8'h00, 0, 1, 8'h77, 1, 0);
        for (int i = 0; i < 4; i++) begin
            chk_rdy($sformatf("stall%0d", i), 0, 0);
            tick;
            chk_out("stall", 1, 8'h5A, 1, 0);
        end
        out_ready = 1'b1;
        chk_rdy("drain", 0, 1);
        tick;
        chk_out("drain", 1, 8'h77, 1, 1);

        // Reset during an in1 lock releases it and clears prio.
        do_reset;
        drive(0, 8'h00, 0, 1, 8'h01, 0, 1);
        tick;
        chk_out("rlock.b1", 1, 8'h01, 0, 1);
        drive(1, 8'h99, 1, 1, 8'h02, 0, 1);
        rst = 1'b1;
        chk_rdy("rlock.rst", 0, 0);
        chk_out("rlock.rst", 0, 8'h00, 0, 0);
        tick;
        rst = 1'b0;
        chk_rdy("rlock.tie", 1, 0);
        tick;
        chk_out("rlock.tie", 1, 8'h99, 1, 0);

        // Randomized run against the model.
        do_reset;
        m_lock = -1; m_prio = 0; m_ov = 0; m_ol = 0; m_os = 0; m_od = 0;
        sv[0] = 0; sv[1] = 0; sd[0] = 0; sd[1] = 0; sl[0] = 0; sl[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            int  g;
            bit  can, acc;
            for (int s = 0; s < 2; s++)
                if (!sv[s]) begin
                    sv[s] = ($urandom % 3) != 0;
                    sd[s] = 8'($urandom);
                    sl[s] = ($urandom % 3) == 0;
                end
            drive(sv[0], sd[0], sl[0], sv[1], sd[1], sl[1], ($urandom % 4) != 0);
            g   = (m_lock >= 0) ? m_lock : ((sv[0] && sv[1]) ? int'(m_prio) : (sv[1] ? 1 : 0));
            can = !m_ov || out_ready;
            acc = can && sv[g];
            chk_rdy("rnd", can && g == 0, can && g == 1);
            tick;
            if (acc) begin
                m_ov = 1; m_od = sd[g]; m_ol = sl[g]; m_os = g[0];
                if (sl[g]) begin
                    m_lock = -1;
                    m_prio = (g == 0);
                end else
                    m_lock = g;
                sv[g] = 0;
            end else if (out_ready)
                m_ov = 0;
            chk_out("rnd", m_ov, m_od, m_ol, m_os);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
